// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: pipelined carry-lookahead add/subtract unit.
// The operand word is split into STAGES slices. Stage k adds slice k with a
// BLOCK-bit grouped lookahead and registers the slice carry into stage k+1.
// Operands travel with the beat (skew) and finished result slices travel
// with it too (deskew), so the last stage register holds the complete result.
// Optional build macro PIPE_CLA_SAT_EN: clamp sum to the signed limit on
// overflow (applied in the final stage, latency unchanged).
module pipe_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int BLOCK  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SL = WIDTH / STAGES;
  localparam int NB = SL / BLOCK;

  // Slice adder. Every carry is written as an explicit sum of products of
  // generate/propagate terms (group level first, then bit level inside each
  // group), so no carry depends on a previously computed carry of its level.
  function automatic logic [SL:0] cla_add(input logic [SL-1:0] x,
                                          input logic [SL-1:0] y,
                                          input logic          ci);
    logic [SL-1:0] p;
    logic [SL-1:0] g;
    logic [SL-1:0] c;
    logic [NB-1:0] gg;
    logic [NB-1:0] gp;
    logic [NB:0]   bc;
    logic          term;
    p = x ^ y;
    g = x & y;
    c = '0;
    for (int j = 0; j < NB; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        term = g[j*BLOCK+i];
        for (int n = i + 1; n < BLOCK; n++) term = term & p[j*BLOCK+n];
        gg[j] = gg[j] | term;
        gp[j] = gp[j] & p[j*BLOCK+i];
      end
    end
    for (int j = 0; j <= NB; j++) begin
      bc[j] = 1'b0;
      for (int m = 0; m <= j; m++) begin
        term = (m == 0) ? ci : gg[(m == 0) ? 0 : m-1];
        for (int n = m; n < j; n++) term = term & gp[n];
        bc[j] = bc[j] | term;
      end
    end
    for (int j = 0; j < NB; j++) begin
      for (int i = 0; i < BLOCK; i++) begin
        c[j*BLOCK+i] = 1'b0;
        for (int m = 0; m <= i; m++) begin
          term = (m == 0) ? bc[j] : g[j*BLOCK + ((m == 0) ? 0 : m-1)];
          for (int n = m; n < i; n++) term = term & p[j*BLOCK+n];
          c[j*BLOCK+i] = c[j*BLOCK+i] | term;
        end
      end
    end
    return {bc[NB], p ^ c};
  endfunction

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  bb_q [STAGES];
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic              ovf_q;

  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_c;
  logic [WIDTH-1:0]  src_a  [STAGES];
  logic [WIDTH-1:0]  src_bb [STAGES];
  logic [WIDTH-1:0]  src_s  [STAGES];
  logic [WIDTH-1:0]  sum_d  [STAGES];
  logic [STAGES-1:0] c_d;
  logic              ovf_d;
  logic [SL:0]       res;
  logic [STAGES:0]   load;

  // Stage k loads when empty or when its beat moves on; out_ready feeds the top.
  always_comb begin
    load = '0;
    load[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = ~v_q[k] | load[k+1];
    end
  end

  assign in_ready = load[0];

  // Per-stage datapath: each stage adds its own slice of the beat it receives.
  always_comb begin
    src_v = '0;
    src_c = '0;
    c_d   = '0;
    res   = '0;
    for (int k = 0; k < STAGES; k++) begin
      src_a[k]  = '0;
      src_bb[k] = '0;
      src_s[k]  = '0;
      sum_d[k]  = '0;
    end
    src_v[0]  = in_valid;
    src_a[0]  = a;
    src_bb[0] = sub ? ~b : b;
    src_c[0]  = sub | cin;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k]  = v_q[k-1];
      src_a[k]  = a_q[k-1];
      src_bb[k] = bb_q[k-1];
      src_s[k]  = s_q[k-1];
      src_c[k]  = c_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      res = cla_add(src_a[k][k*SL +: SL], src_bb[k][k*SL +: SL], src_c[k]);
      sum_d[k] = src_s[k];
      sum_d[k][k*SL +: SL] = res[SL-1:0];
      c_d[k] = res[SL];
    end
    ovf_d = (src_a[STAGES-1][WIDTH-1] == src_bb[STAGES-1][WIDTH-1]) &&
            (sum_d[STAGES-1][WIDTH-1] != src_a[STAGES-1][WIDTH-1]);
`ifdef PIPE_CLA_SAT_EN
    if (ovf_d) begin
      sum_d[STAGES-1] = src_a[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                 : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Stage registers; data only moves with a valid beat so a stalled output holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= '0;
        bb_q[k] <= '0;
        s_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            a_q[k]  <= src_a[k];
            bb_q[k] <= src_bb[k];
            s_q[k]  <= sum_d[k];
            c_q[k]  <= c_d[k];
          end
        end
      end
      if (load[STAGES-1] && src_v[STAGES-1]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: doc/pipe_cla_adder.md
Name: pipe_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead add/subtract unit; successor to the single-bit full adder cell.
- Operand word is split into STAGES equal slices. Each slice is added by a BLOCK-bit lookahead group chain in its own pipeline stage, and the carry is registered between stages.
- Valid/ready handshake on both sides. Sits between operand-issue logic and result consumers in the datapath.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STAGES, 2, pipeline stages. Each stage adds WIDTH/STAGES bits. Legal: WIDTH % STAGES == 0.
- BLOCK, 4, lookahead group size within a slice. Legal: (WIDTH/STAGES) % BLOCK == 0.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in. Ignored when sub=1.
- sub  input  1  1 = compute a - b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of MSB. For sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset is asynchronous, active-high:
  - all stage valid bits clear;
  - out_valid=0, sum=0, cout=0, ovf=0;
  - in_ready=1 once reset deasserts.
- Arithmetic:
  - Effective operands are bb = sub ? ~b : b and c0 = sub ? 1 : cin.
  - Result is {cout, sum} = a + bb + c0, computed modulo 2^(WIDTH+1).
  - ovf = (a[MSB] == bb[MSB]) && (sum[MSB] != a[MSB]).
- Slicing:
  - Stage k adds bits [(k+1)*W/S-1 : k*W/S] using p = a^bb and g = a&bb.
  - Group generate/propagate is formed per BLOCK; carries within the slice come from lookahead, not ripple.
  - Slice carry-out is registered into stage k+1.
  - Operand slices above k are carried forward (skewed); result slices below k are carried forward (deskewed).
- Handshake:
  - An input is accepted on in_valid && in_ready; an output is transferred on out_valid && out_ready.
  - Latency: exactly STAGES cycles from acceptance to out_valid when there is no backpressure.
  - Throughput: 1 beat/cycle sustained.
- Per-stage advance rule: stage k loads when it is empty, or when its current contents move to stage k+1 (or out) in the same cycle.
  - in_ready = !v[0] || advance[0]. It is combinational from out_ready through the chain; there is no skid buffer.
- Backpressure: with out_ready=0, the pipe fills, holding at most STAGES beats. in_ready then drops.
  - No beat is lost or duplicated. Order is preserved.
- Output stability: while out_valid && !out_ready, sum/cout/ovf/out_valid must hold stable.
- Simultaneous push and pop while full: allowed. Occupancy is unchanged and in_ready stays 1.
- Reset mid-operation: all in-flight beats are discarded. No out_valid may assert for a pre-reset beat.
- STAGES=1 degenerates to a single registered CLA with latency 1.
- Inputs are sampled only on acceptance; they are don't-care otherwise.

Optional Feature:
- Macro: PIPE_CLA_SAT_EN.
- Defined:
  - On ovf=1, sum is clamped to the signed limit: 0x7FF..F if a[MSB]==0, else 0x800..0.
  - ovf still reports 1 for that beat; cout is unchanged.
  - Clamp is applied in the final stage; latency is unchanged.
- Undefined: sum wraps modulo 2^WIDTH. ovf is reported only.

Test Plan (WIDTH=32, STAGES=2, BLOCK=4):
- a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, out_ready=1 -> exactly 2 cycles later: out_valid=1, sum=0x00000000, cout=1, ovf=0. This is a full carry chain crossing the slice boundary.
- a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5, sub=1 -> sum=0x00000002, cout=1.
- a=0x7FFFFFFF, b=1, sub=0 -> ovf=1, cout=0.
  - Without the macro: sum=0x80000000.
  - With PIPE_CLA_SAT_EN: sum=0x7FFFFFFF.
  - Also a=0x80000000, b=1, sub=1 -> ovf=1; saturated sum=0x80000000.
- Backpressure: hold out_ready=0 and drive in_valid=1 with beats 1+1, 2+2, 3+3, 4+4.
  - Only 2 beats are accepted; in_ready=0 from the 3rd cycle.
  - Release out_ready -> results 2, 4, 6, 8 appear in order, with sum stable while stalled.
- Throughput: 16 back-to-back beats with out_ready=1 -> in_ready never drops. Results appear on 16 consecutive cycles starting 2 cycles after the first accept.
- Assert reset for 1 cycle while 2 beats are in flight -> out_valid=0, sum=0 immediately (asynchronous). Neither stale result ever appears. The next beat after reset has latency 2.
